fetch_seq_ctrl: RTL and testbench

- Instruction-fetch sequencer that owns the program counter and drives the instruction-memory request handshake.
- Selects the next PC from three sources: sequential PC+4, branch/jump redirect, or exception vector.
- Holds one fetched instruction for the decode stage.
- Sits between the EX/MEM redirect logic, the instruction memory and IF/ID.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_fetch_seq_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
// Holds the FSM state encoding, default reset/exception addresses,
// the instruction size and a small next-sequential-PC helper.
package fetch_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FETCH = 2'd1;
  localparam state_t ST_FULL  = 2'd2;
  localparam state_t ST_DRAIN = 2'd3;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;
  localparam logic [31:0] INSTR_BYTES  = 32'd4;

  // Sequential successor of a fetch address; wraps naturally at 2^32.
  function automatic logic [31:0] nextSeqPc(input logic [31:0] addr);
    return addr + INSTR_BYTES;
  endfunction

endpackage

// File: rtl/fetch_seq_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the instruction-memory
// request handshake and buffers one fetched instruction for decode.
// Next-PC priority: exception vector > redirect target > PC+4.
// Optional feature macro PC_ALIGN_CHK_EN: when defined, a misaligned redirect
// target is replaced by the exception vector and adel_o pulses for one cycle;
// when undefined, the low two bits of the redirect target are cleared and
// adel_o stays low.
module fetch_seq_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] EXC_VEC  = DEF_EXC_VEC
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        exc_req_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o,
  input  logic        if_ready_i,
  output logic [31:0] pc_o,
  output logic        adel_o
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        adel_q, adel_d;

  logic        takeRedir;
  logic [31:0] target;

  // Resolve which control-flow change (if any) is taken and where it goes.
  always_comb begin
    takeRedir = redirect_valid_i | exc_req_i;
`ifdef PC_ALIGN_CHK_EN
    if (exc_req_i || (redirect_pc_i[1:0] != 2'b00)) begin
      target = EXC_VEC;
    end else begin
      target = redirect_pc_i;
    end
    adel_d = redirect_valid_i & ~exc_req_i & (redirect_pc_i[1:0] != 2'b00);
`else
    if (exc_req_i) begin
      target = EXC_VEC;
    end else begin
      target = redirect_pc_i & ~32'h0000_0003;
    end
    adel_d = 1'b0;
`endif
  end

  // Next-state logic for the fetch FSM, PC, request address and buffer.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;

    if (takeRedir) begin
      pc_d       = target;
      if_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        state_d    = ST_FETCH;
        req_addr_d = pc_d;
      end
      ST_FETCH: begin
        if (imem_ack_i) begin
          if (takeRedir) begin
            req_addr_d = target;
          end else begin
            if_instr_d = imem_rdata_i;
            if_pc_d    = req_addr_q;
            if_valid_d = 1'b1;
            pc_d       = nextSeqPc(req_addr_q);
            state_d    = ST_FULL;
          end
        end else if (takeRedir) begin
          state_d = ST_DRAIN;
        end
      end
      ST_FULL: begin
        if (takeRedir) begin
          req_addr_d = target;
          state_d    = ST_FETCH;
        end else if (if_ready_i) begin
          if_valid_d = 1'b0;
          req_addr_d = pc_q;
          state_d    = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (imem_ack_i) begin
          req_addr_d = pc_d;
          state_d    = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      if_valid_q <= 1'b0;
      if_instr_q <= 32'h0;
      if_pc_q    <= 32'h0;
      adel_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      adel_q     <= adel_d;
    end
  end

  assign imem_req_o  = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign imem_addr_o = req_addr_q;
  assign if_valid_o  = if_valid_q;
  assign if_instr_o  = if_instr_q;
  assign if_pc_o     = if_pc_q;
  assign pc_o        = pc_q;
  assign adel_o      = adel_q;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Self-checking bench for fetch_seq_ctrl: a directed vector table, a few
// hand-written corner sequences (misaligned redirect, async reset mid-fetch)
// and a randomized run compared against a transaction-level reference model.
module tb_fetch_seq_ctrl;

  localparam logic [31:0] RPC = 32'h0000_3000;
  localparam logic [31:0] EV  = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        exc_req;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic [31:0] pc;
  logic        adel;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  fetch_seq_ctrl dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .exc_req_i        (exc_req),
    .imem_req_o       (imem_req),
    .imem_addr_o      (imem_addr),
    .imem_ack_i       (imem_ack),
    .imem_rdata_i     (imem_rdata),
    .if_valid_o       (if_valid),
    .if_instr_o       (if_instr),
    .if_pc_o          (if_pc),
    .if_ready_i       (if_ready),
    .pc_o             (pc),
    .adel_o           (adel)
  );

  typedef struct {
    logic        rv;
    logic [31:0] rp;
    logic        ex;
    logic        ak;
    logic [31:0] rd;
    logic        rdy;
    logic        eReq;
    logic [31:0] eAddr;
    logic        eValid;
    logic [31:0] eInstr;
    logic [31:0] eIfPc;
    logic [31:0] ePc;
  } vec_t;

  vec_t vecs[22];

  // Reference model: one outstanding request, a drop flag for stale data,
  // a one-entry buffer and a pending start after reset release.
  logic        mStart, mReqActive, mDrop, mBufValid, mAdel;
  logic [31:0] mPc, mReqAddr, mBufInstr, mBufPc;

  function automatic vec_t mk(input logic rv, input logic [31:0] rp, input logic ex,
                              input logic ak, input logic [31:0] rd, input logic rdy,
                              input logic eReq, input logic [31:0] eAddr, input logic eValid,
                              input logic [31:0] eInstr, input logic [31:0] eIfPc,
                              input logic [31:0] ePc);
    vec_t v;
    v.rv = rv; v.rp = rp; v.ex = ex; v.ak = ak; v.rd = rd; v.rdy = rdy;
    v.eReq = eReq; v.eAddr = eAddr; v.eValid = eValid;
    v.eInstr = eInstr; v.eIfPc = eIfPc; v.ePc = ePc;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic [31:0] rp, input logic ex,
                               input logic ak, input logic [31:0] rd, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rp;
    exc_req        = ex;
    imem_ack       = ak;
    imem_rdata     = rd;
    if_ready       = rdy;
  endtask

  task automatic modelReset();
    mStart = 1'b1; mReqActive = 1'b0; mDrop = 1'b0; mBufValid = 1'b0; mAdel = 1'b0;
    mPc = RPC; mReqAddr = RPC; mBufInstr = 32'h0; mBufPc = 32'h0;
  endtask

  task automatic modelStep(input logic rv, input logic [31:0] rp, input logic ex,
                           input logic ak, input logic [31:0] rd, input logic rdy);
    logic take;
    logic [31:0] tgt;
    take = rv | ex;
`ifdef PC_ALIGN_CHK_EN
    tgt   = (ex || (rp % 4 != 0)) ? EV : rp;
    mAdel = rv && !ex && (rp % 4 != 0);
`else
    tgt   = ex ? EV : rp - (rp % 4);
    mAdel = 1'b0;
`endif
    if (mStart) begin
      mStart = 1'b0;
      if (take) mPc = tgt;
      mReqActive = 1'b1;
      mDrop = 1'b0;
      mReqAddr = mPc;
    end else if (mReqActive) begin
      if (take) begin
        mPc = tgt;
        mBufValid = 1'b0;
      end
      if (ak) begin
        if (mDrop) begin
          mDrop = 1'b0;
          mReqAddr = mPc;
        end else if (take) begin
          mReqAddr = tgt;
        end else begin
          mBufValid = 1'b1;
          mBufInstr = rd;
          mBufPc = mReqAddr;
          mPc = mReqAddr + 32'd4;
          mReqActive = 1'b0;
        end
      end else if (take) begin
        mDrop = 1'b1;
      end
    end else begin
      if (take) begin
        mPc = tgt; mBufValid = 1'b0; mReqActive = 1'b1; mReqAddr = tgt;
      end else if (rdy) begin
        mBufValid = 1'b0; mReqActive = 1'b1; mReqAddr = mPc;
      end
    end
  endtask

  task automatic checkAgainstModel(input int cyc);
    checkOutput($sformatf("rnd%0d_req", cyc), {31'b0, imem_req}, {31'b0, mReqActive});
    if (mReqActive) checkOutput($sformatf("rnd%0d_addr", cyc), imem_addr, mReqAddr);
    checkOutput($sformatf("rnd%0d_valid", cyc), {31'b0, if_valid}, {31'b0, mBufValid});
    if (mBufValid) begin
      checkOutput($sformatf("rnd%0d_instr", cyc), if_instr, mBufInstr);
      checkOutput($sformatf("rnd%0d_ifpc", cyc), if_pc, mBufPc);
    end
    checkOutput($sformatf("rnd%0d_pc", cyc), pc, mPc);
    checkOutput($sformatf("rnd%0d_adel", cyc), {31'b0, adel}, {31'b0, mAdel});
  endtask

  initial begin
    logic [31:0] expHandPc;
    logic        expAdel;
    logic        rv, ex, ak, rdy;
    logic [31:0] rp, rd;

    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Directed table: throughput, delayed ack, stall, drain, exception priority.
    vecs[0]  = mk(0, 0, 0, 1, 32'h0,         1, 0, RPC,          0, 0, 0, 32'h3000);
    vecs[1]  = mk(0, 0, 0, 1, 32'h1111_0000, 1, 1, 32'h3000,     0, 0, 0, 32'h3000);
    vecs[2]  = mk(0, 0, 0, 1, 32'h0,         1, 0, 0,            1, 32'h1111_0000, 32'h3000, 32'h3004);
    vecs[3]  = mk(0, 0, 0, 1, 32'h1111_0001, 1, 1, 32'h3004,     0, 0, 0, 32'h3004);
    vecs[4]  = mk(0, 0, 0, 1, 32'h0,         1, 0, 0,            1, 32'h1111_0001, 32'h3004, 32'h3008);
    vecs[5]  = mk(0, 0, 0, 1, 32'h1111_0002, 1, 1, 32'h3008,     0, 0, 0, 32'h3008);
    vecs[6]  = mk(0, 0, 0, 1, 32'h0,         1, 0, 0,            1, 32'h1111_0002, 32'h3008, 32'h300C);
    vecs[7]  = mk(0, 0, 0, 0, 32'h0,         1, 1, 32'h300C,     0, 0, 0, 32'h300C);
    vecs[8]  = mk(0, 0, 0, 0, 32'h0,         0, 1, 32'h300C,     0, 0, 0, 32'h300C);
    vecs[9]  = mk(0, 0, 0, 0, 32'h0,         0, 1, 32'h300C,     0, 0, 0, 32'h300C);
    vecs[10] = mk(0, 0, 0, 1, 32'h1111_0003, 0, 1, 32'h300C,     0, 0, 0, 32'h300C);
    for (int i = 11; i < 16; i++)
      vecs[i] = mk(0, 0, 0, 0, 32'h0,        0, 0, 0,            1, 32'h1111_0003, 32'h300C, 32'h3010);
    vecs[16] = mk(0, 0, 0, 0, 32'h0,         1, 0, 0,            1, 32'h1111_0003, 32'h300C, 32'h3010);
    vecs[17] = mk(1, 32'h3100, 0, 0, 32'h0,  0, 1, 32'h3010,     0, 0, 0, 32'h3010);
    vecs[18] = mk(0, 0, 0, 0, 32'h0,         0, 1, 32'h3010,     0, 0, 0, 32'h3100);
    vecs[19] = mk(0, 0, 0, 1, 32'hDEAD_BEEF, 0, 1, 32'h3010,     0, 0, 0, 32'h3100);
    vecs[20] = mk(0, 0, 0, 1, 32'h2222_0000, 0, 1, 32'h3100,     0, 0, 0, 32'h3100);
    vecs[21] = mk(1, 32'h3200, 1, 0, 32'h0,  1, 0, 0,            1, 32'h2222_0000, 32'h3100, 32'h3104);

    // Reset values while reset is held.
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_req", {31'b0, imem_req}, 32'h0);
    checkOutput("reset_addr", imem_addr, RPC);
    checkOutput("reset_valid", {31'b0, if_valid}, 32'h0);
    checkOutput("reset_instr", if_instr, 32'h0);
    checkOutput("reset_ifpc", if_pc, 32'h0);
    checkOutput("reset_pc", pc, RPC);
    checkOutput("reset_adel", {31'b0, adel}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i].rv, vecs[i].rp, vecs[i].ex, vecs[i].ak, vecs[i].rd, vecs[i].rdy);
      #1;
      checkOutput($sformatf("row%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].eReq});
      if (vecs[i].eReq) checkOutput($sformatf("row%0d_addr", i), imem_addr, vecs[i].eAddr);
      checkOutput($sformatf("row%0d_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].eValid});
      if (vecs[i].eValid) begin
        checkOutput($sformatf("row%0d_instr", i), if_instr, vecs[i].eInstr);
        checkOutput($sformatf("row%0d_ifpc", i), if_pc, vecs[i].eIfPc);
      end
      checkOutput($sformatf("row%0d_pc", i), pc, vecs[i].ePc);
      checkOutput($sformatf("row%0d_adel", i), {31'b0, adel}, 32'h0);
      @(posedge clk);
      @(negedge clk);
    end

    // Fetch of the exception vector completes, then a misaligned redirect.
    applyStimulus(0, 32'h0, 0, 1, 32'h3333_0000, 0);
    #1;
    checkOutput("exc_fetch_req", {31'b0, imem_req}, 32'h1);
    checkOutput("exc_fetch_addr", imem_addr, EV);
    checkOutput("exc_fetch_pc", pc, EV);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1, 32'h3102, 0, 0, 32'h0, 0);
    #1;
    checkOutput("exc_full_valid", {31'b0, if_valid}, 32'h1);
    checkOutput("exc_full_ifpc", if_pc, EV);
    checkOutput("exc_full_pc", pc, EV + 32'd4);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 0);
    #1;
`ifdef PC_ALIGN_CHK_EN
    expHandPc = EV;
    expAdel   = 1'b1;
`else
    expHandPc = 32'h3100;
    expAdel   = 1'b0;
`endif
    checkOutput("misalign_req", {31'b0, imem_req}, 32'h1);
    checkOutput("misalign_addr", imem_addr, expHandPc);
    checkOutput("misalign_pc", pc, expHandPc);
    checkOutput("misalign_valid", {31'b0, if_valid}, 32'h0);
    checkOutput("misalign_adel", {31'b0, adel}, {31'b0, expAdel});
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("adel_single_pulse", {31'b0, adel}, 32'h0);
    checkOutput("fetch_before_reset_req", {31'b0, imem_req}, 32'h1);

    // Asynchronous reset in the middle of a pending fetch.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_req", {31'b0, imem_req}, 32'h0);
    checkOutput("async_reset_pc", pc, RPC);
    checkOutput("async_reset_valid", {31'b0, if_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();

    // Randomized run against the reference model.
    for (int c = 0; c < 3000; c++) begin
      rv  = ($urandom_range(0, 7) == 0);
      ex  = ($urandom_range(0, 15) == 0);
      rp  = $urandom;
      if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
      ak  = $urandom_range(0, 1) == 1;
      rd  = $urandom;
      rdy = $urandom_range(0, 1) == 1;
      applyStimulus(rv, rp, ex, ak, rd, rdy);
      #1;
      checkAgainstModel(c);
      @(posedge clk);
      modelStep(rv, rp, ex, ak, rd, rdy);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
